// File: rtl/param_counter.sv
// Parameterised modulo up/down counter. It supports a synchronous clear, a parallel
// load and a choice of wrap or saturate at the ends of the count range.
module param_counter #(
    parameter int     WIDTH    = 8,
    parameter longint MODULUS  = 256,
    parameter bit     SATURATE = 1'b0
) (
    input  logic             CLK,
    input  logic             Clear,
    input  logic             D,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] Din,
    input  logic             Sync_clr,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             Wrap,
    output logic             Sat
);

    // MODULUS can be 2^WIDTH. The top value therefore fits in WIDTH bits, and every
    // comparison below stays WIDTH-bit wide.
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic             at_top;
    logic             at_bot;
    logic [WIDTH-1:0] load_val;

    assign at_top   = (Q == MAX);
    assign at_bot   = (Q == '0);
    assign load_val = (Din > MAX) ? MAX : Din;

    // Terminal count looks only at enable, direction and Q. It ignores Load and Sync_clr.
    assign TC = D && (Up ? at_top : at_bot);

    // NOTE: state registers use non-blocking assignments. Every flop then samples
    // pre-edge values, whatever order the statements are written in.
    always_ff @(posedge CLK or negedge Clear) begin
        if (!Clear) begin
            Q    <= '0;
            Wrap <= 1'b0;
            Sat  <= 1'b0;
        end else if (Sync_clr) begin
            Q    <= '0;
            Wrap <= 1'b0;
            Sat  <= 1'b0;
        end else if (Load) begin
            Q    <= load_val;
            Wrap <= 1'b0;
            Sat  <= 1'b0;
        end else if (D) begin
            if (Up ? at_top : at_bot) begin
                if (SATURATE) begin
                    Wrap <= 1'b0;
                    Sat  <= 1'b1;
                end else begin
                    Q    <= Up ? '0 : MAX;
                    Wrap <= 1'b1;
                    Sat  <= 1'b0;
                end
            end else begin
                Q    <= Up ? Q + WIDTH'(1) : Q - WIDTH'(1);
                Wrap <= 1'b0;
                Sat  <= 1'b0;
            end
        end else begin
            // When idle, Wrap clears and Sat keeps the result of the last enabled step.
            Wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_param_counter.sv
// Self-checking bench for param_counter. Three instances run side by side: the default
// wrap-256 counter, a wrap-10 counter and a saturate-10 counter.
module tb_param_counter;

    logic       clk;
    logic       clear;
    logic       d;
    logic       up;
    logic       load;
    logic       sync_clr;
    logic [7:0] din;

    logic [7:0] q0;
    logic [3:0] q1, q2;
    logic [2:0] tc, wrap, sat;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, indexed by instance.
    int modv [3] = '{256, 10, 10};
    bit satm [3] = '{1'b0, 1'b0, 1'b1};
    int mq   [3];
    bit mwrap[3];
    bit msat [3];

    param_counter #(.WIDTH(8), .MODULUS(256), .SATURATE(1'b0)) u_dflt (
        .CLK(clk), .Clear(clear), .D(d), .Up(up), .Load(load), .Din(din),
        .Sync_clr(sync_clr), .Q(q0), .TC(tc[0]), .Wrap(wrap[0]), .Sat(sat[0])
    );

    param_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_wrap10 (
        .CLK(clk), .Clear(clear), .D(d), .Up(up), .Load(load), .Din(din[3:0]),
        .Sync_clr(sync_clr), .Q(q1), .TC(tc[1]), .Wrap(wrap[1]), .Sat(sat[1])
    );

    param_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_sat10 (
        .CLK(clk), .Clear(clear), .D(d), .Up(up), .Load(load), .Din(din[3:0]),
        .Sync_clr(sync_clr), .Q(q2), .TC(tc[2]), .Wrap(wrap[2]), .Sat(sat[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] obs_q(int i);
        case (i)
            0:       return {56'b0, q0};
            1:       return {60'b0, q1};
            default: return {60'b0, q2};
        endcase
    endfunction

    task automatic check(string tag, logic [63:0] observed, logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mq[i]    = 0;
            mwrap[i] = 1'b0;
            msat[i]  = 1'b0;
        end
    endtask

    // One rising edge of the specified behaviour. Steps are plain integer arithmetic,
    // and out-of-range results are folded back with a modulo.
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            int dv;
            int nxt;
            dv = (i == 0) ? int'(din) : int'(din[3:0]);
            if (sync_clr) begin
                mq[i] = 0; mwrap[i] = 1'b0; msat[i] = 1'b0;
            end else if (load) begin
                mq[i] = (dv < modv[i]) ? dv : modv[i] - 1;
                mwrap[i] = 1'b0; msat[i] = 1'b0;
            end else if (d) begin
                nxt = up ? mq[i] + 1 : mq[i] - 1;
                if (nxt < 0 || nxt >= modv[i]) begin
                    if (satm[i]) begin
                        mwrap[i] = 1'b0; msat[i] = 1'b1;
                    end else begin
                        mq[i] = (nxt + modv[i]) % modv[i];
                        mwrap[i] = 1'b1; msat[i] = 1'b0;
                    end
                end else begin
                    mq[i] = nxt; mwrap[i] = 1'b0; msat[i] = 1'b0;
                end
            end else begin
                mwrap[i] = 1'b0;
            end
        end
    endtask

    function automatic bit model_tc(int i);
        return d && (up ? (mq[i] == modv[i] - 1) : (mq[i] == 0));
    endfunction

    task automatic check_tc(string tag);
        for (int i = 0; i < 3; i++)
            check($sformatf("%s_tc%0d", tag, i), {63'b0, tc[i]}, {63'b0, model_tc(i)});
    endtask

    task automatic check_state(string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_q%0d", tag, i), obs_q(i), 64'(mq[i]));
            check($sformatf("%s_wrap%0d", tag, i), {63'b0, wrap[i]}, {63'b0, mwrap[i]});
            check($sformatf("%s_sat%0d", tag, i), {63'b0, sat[i]}, {63'b0, msat[i]});
        end
    endtask

    // Called between edges. Drives the inputs, checks TC, takes one edge, then checks state.
    task automatic step(string tag, logic d_i, logic up_i, logic load_i,
                        logic sclr_i, logic [7:0] din_i);
        d = d_i; up = up_i; load = load_i; sync_clr = sclr_i; din = din_i;
        #1;
        check_tc(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_state(tag);
    endtask

    initial begin
        clear = 1'b0; d = 1'b0; up = 1'b1; load = 1'b0; sync_clr = 1'b0; din = '0;
        model_reset();

        // Reset state. With Clear low, synchronous inputs are ignored but TC stays live.
        @(negedge clk);
        check_state("reset");
        check_tc("reset");
        d = 1'b1; up = 1'b0; load = 1'b1; din = 8'd77;
        #1;
        check("reset_tc_down", {63'b0, tc[0]}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        check_state("reset_ignored");

        // Release Clear mid-cycle, then count up through a full 256-value period.
        #2 clear = 1'b1;
        for (int k = 0; k < 256; k++) step("up256", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        check("up256_end_q", obs_q(0), 64'd0);
        check("up256_end_wrap", {63'b0, wrap[0]}, 64'd1);

        // Mod-10 down count from 0.
        step("sclr", 1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
        step("down10_first", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        check("down10_q9", obs_q(1), 64'd9);
        check("down10_wrap", {63'b0, wrap[1]}, 64'd1);
        for (int k = 0; k < 10; k++) step("down10", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        check("down10_last_q", obs_q(1), 64'd9);

        // Out-of-range load clips to the top value. Sync_clr beats Load.
        step("load15", 1'b0, 1'b1, 1'b1, 1'b0, 8'd15);
        check("load15_q", obs_q(1), 64'd9);
        step("load_vs_sclr", 1'b0, 1'b1, 1'b1, 1'b1, 8'd4);
        check("load_vs_sclr_q", obs_q(1), 64'd0);

        // Saturation at the top, then a direction change.
        step("load8", 1'b0, 1'b1, 1'b1, 1'b0, 8'd8);
        for (int k = 0; k < 4; k++) step("sat_up", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        check("sat_q", obs_q(2), 64'd9);
        check("sat_flag", {63'b0, sat[2]}, 64'd1);
        check("sat_wrap", {63'b0, wrap[2]}, 64'd0);
        step("sat_down", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        check("sat_down_q", obs_q(2), 64'd8);
        check("sat_down_flag", {63'b0, sat[2]}, 64'd0);

        // Hold at 37, then an asynchronous clear between edges.
        step("load37", 1'b0, 1'b1, 1'b1, 1'b0, 8'd37);
        for (int k = 0; k < 20; k++) step("hold", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        check("hold_q", obs_q(0), 64'd37);
        #3 clear = 1'b0;
        #1;
        model_reset();
        check("async_clr_q", obs_q(0), 64'd0);
        check_state("async_clr");
        @(negedge clk);
        #2 clear = 1'b1;

        // Randomised traffic against the model.
        for (int k = 0; k < 400; k++) begin
            step("rand", ($urandom_range(0, 9) < 7), 1'($urandom),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 29) == 0),
                 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/param_counter.md
PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits (2..32).
REQ-002 Parameter MODULUS, default 256, count range 0..MODULUS-1; legal 2..2^WIDTH.
REQ-003 Parameter SATURATE, default 0; 0 = wrap at limits, 1 = hold at limits.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 Clear  input  1  reset, asynchronous, active-low (Clear=0 resets immediately).
REQ-006 D  input  1  count enable; 1 = count one step this cycle.
REQ-007 Up  input  1  direction; 1 = increment, 0 = decrement.
REQ-008 Load  input  1  synchronous parallel load strobe.
REQ-009 Din  input  WIDTH  parallel load value.
REQ-010 Sync_clr  input  1  synchronous clear to 0.
REQ-011 Q  output  WIDTH  registered count value.
REQ-012 TC  output  1  combinational terminal count: D=1 and Q at current-direction limit.
REQ-013 Wrap  output  1  registered one-cycle pulse, set on cycle after a wrap occurred.
REQ-014 Sat  output  1  registered level, 1 while SATURATE=1 and last enabled step was blocked at a limit.

Function
REQ-015 Per-edge priority SHALL be: Sync_clr > Load > D count > hold.
REQ-016 Sync_clr=1: Q<=0, Wrap<=0, Sat<=0, regardless of D/Load.
REQ-017 Load=1: Q<=Din if Din<MODULUS, else Q<=MODULUS-1; Wrap<=0, Sat<=0.
REQ-018 D=1, Up=1, Q<MODULUS-1: Q<=Q+1; Wrap<=0; Sat<=0.
REQ-019 D=1, Up=0, Q>0: Q<=Q-1; Wrap<=0; Sat<=0.
REQ-020 Up limit (D=1, Up=1, Q=MODULUS-1): SATURATE=0 -> Q<=0, Wrap<=1; SATURATE=1 -> Q holds, Sat<=1, Wrap<=0.
REQ-021 Down limit (D=1, Up=0, Q=0): SATURATE=0 -> Q<=MODULUS-1, Wrap<=1; SATURATE=1 -> Q holds, Sat<=1, Wrap<=0.
REQ-022 D=0 with no Load/Sync_clr: Q holds; Wrap<=0; Sat holds.
REQ-023 TC SHALL be 1 iff D=1 and ((Up=1 and Q=MODULUS-1) or (Up=0 and Q=0)), independent of Load/Sync_clr.
REQ-024 Direction change on any cycle SHALL take effect that same edge; no pipeline latency on Q (1-cycle update).
REQ-025 When MODULUS=2^WIDTH, arithmetic SHALL be WIDTH-bit; no intermediate bit may leak into Q.
REQ-026 Q SHALL never hold a value >= MODULUS in any reachable state.

Reset
REQ-027 Clear=0 SHALL force Q=0, Wrap=0, Sat=0 asynchronously, without waiting for CLK.
REQ-028 While Clear=0, all synchronous inputs SHALL be ignored; TC follows REQ-023 from Q=0.
REQ-029 On Clear release, first counting edge SHALL be the first rising CLK with Clear=1; mid-count assertion abandons count with no Wrap pulse.

Verification
REQ-030 Defaults, Clear=0 mid-cycle then 1, D=1, Up=1, 256 clocks -> Q 0..255 then 0; Wrap=1 one cycle after 255->0; TC=1 only at Q=255.
REQ-031 MODULUS=10, Up=0, D=1 from Q=0 -> Q=9,8,...,0,9; Wrap pulses after 0->9.
REQ-032 MODULUS=10, Load=1, Din=15 -> Q=9; Din=4 with Sync_clr=1 same cycle -> Q=0.
REQ-033 SATURATE=1, MODULUS=10, Up=1 from Q=8, D=1 4 clocks -> Q=9,9,9,9; Sat=1 from second edge; Wrap stays 0; Up=0 -> Q=8, Sat=0.
REQ-034 D=0 for 20 clocks at Q=37 -> Q stays 37, TC=0, Wrap=0; Clear=0 between edges -> Q=0 before next CLK edge.
